// File: rtl/calendar_bcd.sv
// BCD day/month/year/weekday calendar with Gregorian leap rules and validated loads.
// Latency: 1 cycle from day_tick/set_en to updated outputs and pulses; no backpressure, every event is consumed.
module calendar_bcd #(
   parameter int         YEAR_DIGITS   = 4,
   parameter logic [7:0] BASE_CENTURY  = 8'h20,
   parameter logic [7:0] RESET_DAY     = 8'h01,
   parameter logic [7:0] RESET_MONTH   = 8'h01,
   parameter logic [15:0] RESET_YEAR   = 16'h2000,
   parameter logic [2:0] RESET_WEEKDAY = 3'd5,
   localparam int        YW            = 4*YEAR_DIGITS
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           day_tick,
   input  logic           set_en,
   input  logic [15+YW:0] set_date,
   input  logic [2:0]     set_weekday,
   output logic [15+YW:0] date_out,
   output logic [2:0]     weekday_out,
   output logic           month_tick,
   output logic           year_tick,
   output logic           set_ack,
   output logic           set_err
);

   localparam int NIBBLES = 4 + YEAR_DIGITS;

   logic [7:0]    day, month;
   logic [YW-1:0] year;
   logic [2:0]    weekday;

   // BCD byte (assumed valid BCD) divisible by 4: tens parity selects the ones set.
   function automatic logic bcd_div4(input logic [7:0] b);
      if (b[4]) bcd_div4 = (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
      else      bcd_div4 = (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
   endfunction

   function automatic logic is_leap(input logic [YW-1:0] y);
      logic [7:0] cc;
      if (YEAR_DIGITS == 4) cc = y[YW-1:YW-8];
      else                  cc = BASE_CENTURY;
      is_leap = (y[7:0] == 8'h00) ? bcd_div4(cc) : bcd_div4(y[7:0]);
   endfunction

   function automatic logic [7:0] last_day(input logic [7:0] m, input logic [YW-1:0] y);
      case (m)
         8'h02:                      last_day = is_leap(y) ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: last_day = 8'h30;
         default:                    last_day = 8'h31;
      endcase
   endfunction

   function automatic logic [7:0] day_inc(input logic [7:0] d);
      if (d[3:0] == 4'd9) day_inc = {d[7:4] + 4'd1, 4'h0};
      else                day_inc = {d[7:4], d[3:0] + 4'd1};
   endfunction

   function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] y);
      logic [YW-1:0] r;
      logic          carry;
      r     = y;
      carry = 1'b1;
      for (int i = 0; i < YEAR_DIGITS; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      year_inc = r;
   endfunction

   logic [7:0]    s_day, s_month;
   logic [YW-1:0] s_year;
   logic          nibbles_ok, set_valid;

   assign s_day   = set_date[15+YW -: 8];
   assign s_month = set_date[7+YW -: 8];
   assign s_year  = set_date[YW-1:0];

   always_comb begin
      nibbles_ok = 1'b1;
      for (int i = 0; i < NIBBLES; i++) begin
         if (set_date[4*i +: 4] > 4'd9) nibbles_ok = 1'b0;
      end
   end

   // Byte-wise BCD compares are numeric compares once every nibble is known to be <= 9.
   assign set_valid = nibbles_ok
                   && (s_month >= 8'h01) && (s_month <= 8'h12)
                   && (s_day != 8'h00) && (s_day <= last_day(s_month, s_year))
                   && (set_weekday <= 3'd6);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day        <= RESET_DAY;
         month      <= RESET_MONTH;
         year       <= RESET_YEAR[YW-1:0];
         weekday    <= RESET_WEEKDAY;
         month_tick <= 1'b0;
         year_tick  <= 1'b0;
         set_ack    <= 1'b0;
         set_err    <= 1'b0;
      end else begin
         month_tick <= 1'b0;
         year_tick  <= 1'b0;
         set_ack    <= 1'b0;
         set_err    <= 1'b0;
         if (set_en) begin
            // A load wins over a coincident tick, even when the load is rejected.
            if (set_valid) begin
               day     <= s_day;
               month   <= s_month;
               year    <= s_year;
               weekday <= set_weekday;
               set_ack <= 1'b1;
            end else begin
               set_err <= 1'b1;
            end
         end else if (day_tick) begin
            weekday <= (weekday == 3'd6) ? 3'd0 : weekday + 3'd1;
            if (day < last_day(month, year)) begin
               day <= day_inc(day);
            end else begin
               day        <= 8'h01;
               month_tick <= 1'b1;
               if (month == 8'h12) begin
                  month     <= 8'h01;
                  year      <= year_inc(year);
                  year_tick <= 1'b1;
               end else begin
                  month <= (month == 8'h09) ? 8'h10 : month + 8'h01;
               end
            end
         end
      end
   end

   assign date_out    = {day, month, year};
   assign weekday_out = weekday;

endmodule

// File: tb/tb_calendar_bcd.sv
// Self-checking bench for calendar_bcd: one 4-digit instance and two 2-digit instances (centuries 21 and 20).
module tb_calendar_bcd;

   typedef struct packed {
      logic [31:0] date;
      logic [2:0]  wd;
      logic        mt;
      logic        yt;
      logic        ack;
      logic        err;
   } obs_t;

   typedef struct packed {
      logic [1:0]  g;
      logic        set;
      logic        tick;
      logic [31:0] date;
      logic [2:0]  wd;
      obs_t        exp;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick0, set0, tick2, set2;
   logic [31:0] sd0;
   logic [23:0] sd2;
   logic [2:0]  sw0, sw2;

   logic [31:0] d0;
   logic [23:0] d1, d2;
   logic [2:0]  w0, w1, w2;
   logic        mt0, yt0, ack0, err0;
   logic        mt1, yt1, ack1, err1;
   logic        mt2, yt2, ack2, err2;

   int tests = 0;
   int fails = 0;

   stim_t stim_q[$];
   obs_t  sb[$];

   always #5 clk = ~clk;

   calendar_bcd u_dut4 (
      .clk(clk), .rst_n(rst_n), .day_tick(tick0), .set_en(set0), .set_date(sd0),
      .set_weekday(sw0), .date_out(d0), .weekday_out(w0), .month_tick(mt0),
      .year_tick(yt0), .set_ack(ack0), .set_err(err0)
   );

   calendar_bcd #(.YEAR_DIGITS(2), .BASE_CENTURY(8'h21)) u_dut2_c21 (
      .clk(clk), .rst_n(rst_n), .day_tick(tick2), .set_en(set2), .set_date(sd2),
      .set_weekday(sw2), .date_out(d1), .weekday_out(w1), .month_tick(mt1),
      .year_tick(yt1), .set_ack(ack1), .set_err(err1)
   );

   calendar_bcd #(.YEAR_DIGITS(2), .BASE_CENTURY(8'h20)) u_dut2_c20 (
      .clk(clk), .rst_n(rst_n), .day_tick(tick2), .set_en(set2), .set_date(sd2),
      .set_weekday(sw2), .date_out(d2), .weekday_out(w2), .month_tick(mt2),
      .year_tick(yt2), .set_ack(ack2), .set_err(err2)
   );

   function automatic obs_t observe(input logic [1:0] g);
      obs_t o;
      case (g)
         2'd0:    o = '{date: d0,          wd: w0, mt: mt0, yt: yt0, ack: ack0, err: err0};
         2'd1:    o = '{date: {8'h00, d1}, wd: w1, mt: mt1, yt: yt1, ack: ack1, err: err1};
         default: o = '{date: {8'h00, d2}, wd: w2, mt: mt2, yt: yt2, ack: ack2, err: err2};
      endcase
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("date=%h wd=%0d mt=%b yt=%b ack=%b err=%b", o.date, o.wd, o.mt, o.yt, o.ack, o.err);
   endfunction

   task automatic add(input logic [1:0] g, input logic set, input logic tick,
                      input logic [31:0] d, input logic [2:0] w,
                      input logic [31:0] ed, input logic [2:0] ew,
                      input logic mt, input logic yt, input logic ack, input logic err);
      stim_t st;
      st.g    = g;
      st.set  = set;
      st.tick = tick;
      st.date = d;
      st.wd   = w;
      st.exp  = '{date: ed, wd: ew, mt: mt, yt: yt, ack: ack, err: err};
      stim_q.push_back(st);
   endtask

   task automatic drive(input stim_t st);
      @(negedge clk);
      if (st.g == 2'd0) begin
         set0 = st.set; tick0 = st.tick; sd0 = st.date; sw0 = st.wd;
      end else begin
         set2 = st.set; tick2 = st.tick; sd2 = st.date[23:0]; sw2 = st.wd;
      end
      @(posedge clk);
      #1;
      set0 = 1'b0; tick0 = 1'b0; set2 = 1'b0; tick2 = 1'b0;
   endtask

   task automatic test_reset();
      obs_t o, e;
      #1;
      rst_n = 1'b0;
      #1;
      o = observe(2'd0); e = '{date: 32'h01012000, wd: 3'd5, mt: 0, yt: 0, ack: 0, err: 0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_4digit: got %s expected %s", fmt(o), fmt(e)); end
      o = observe(2'd2); e = '{date: 32'h00010100, wd: 3'd5, mt: 0, yt: 0, ack: 0, err: 0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_2digit: got %s expected %s", fmt(o), fmt(e)); end
      @(negedge clk);
      rst_n = 1'b1;
      // Move away from the reset date, then reset asynchronously in the middle of a cycle.
      add(2'd0, 1, 0, 32'h15062030, 3'd2, 32'h15062030, 3'd2, 0, 0, 1, 0);
      drive(stim_q.pop_front());
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      o = observe(2'd0); e = '{date: 32'h01012000, wd: 3'd5, mt: 0, yt: 0, ack: 0, err: 0};
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_async: got %s expected %s", fmt(o), fmt(e)); end
      @(negedge clk);
      set0 = 1'b1; tick0 = 1'b1; sd0 = 32'h15062030; sw0 = 3'd2;
      @(posedge clk);
      #1;
      set0 = 1'b0; tick0 = 1'b0;
      o = observe(2'd0);
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_overrides_set: got %s expected %s", fmt(o), fmt(e)); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_leap();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd0, 1, 0, 32'h28022000, 3'd0, 32'h28022000, 3'd0, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h29022000, 3'd1, 0, 0, 0, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01032000, 3'd2, 1, 0, 0, 0);
      add(2'd0, 1, 0, 32'h28022100, 3'd0, 32'h28022100, 3'd0, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01032100, 3'd1, 1, 0, 0, 0);
      add(2'd0, 1, 0, 32'h28022024, 3'd2, 32'h28022024, 3'd2, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h29022024, 3'd3, 0, 0, 0, 0);
      add(2'd0, 1, 0, 32'h28021900, 3'd2, 32'h28021900, 3'd2, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01031900, 3'd3, 1, 0, 0, 0);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL leap step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   task automatic test_day_advance();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd0, 1, 0, 32'h30042024, 3'd0, 32'h30042024, 3'd0, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01052024, 3'd1, 1, 0, 0, 0);
      add(2'd0, 1, 0, 32'h19032024, 3'd0, 32'h19032024, 3'd0, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h20032024, 3'd1, 0, 0, 0, 0);
      add(2'd0, 1, 0, 32'h31012024, 3'd0, 32'h31012024, 3'd0, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01022024, 3'd1, 1, 0, 0, 0);
      add(2'd0, 1, 0, 32'h30112024, 3'd5, 32'h30112024, 3'd5, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01122024, 3'd6, 1, 0, 0, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h02122024, 3'd0, 0, 0, 0, 0);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL day_advance step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   task automatic test_year_rollover();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd0, 1, 0, 32'h31122099, 3'd3, 32'h31122099, 3'd3, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01012100, 3'd4, 1, 1, 0, 0);
      add(2'd0, 0, 0, 32'h0,        3'd0, 32'h01012100, 3'd4, 0, 0, 0, 0);
      add(2'd0, 1, 0, 32'h31129999, 3'd6, 32'h31129999, 3'd6, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01010000, 3'd0, 1, 1, 0, 0);
      add(2'd0, 1, 0, 32'h31121999, 3'd4, 32'h31121999, 3'd4, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h01012000, 3'd5, 1, 1, 0, 0);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL year_rollover step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   task automatic test_validation();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd0, 1, 0, 32'h10012024, 3'd2, 32'h10012024, 3'd2, 0, 0, 1, 0);
      add(2'd0, 1, 0, 32'h31042024, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h29022023, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h1A012024, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h15012024, 3'd7, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h00012024, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h15132024, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h150120A4, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 1, 32'h31062024, 3'd1, 32'h10012024, 3'd2, 0, 0, 0, 1);
      add(2'd0, 1, 0, 32'h29022024, 3'd3, 32'h29022024, 3'd3, 0, 0, 1, 0);
      add(2'd0, 0, 0, 32'h0,        3'd0, 32'h29022024, 3'd3, 0, 0, 0, 0);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL validation step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   task automatic test_collision();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd0, 1, 0, 32'h31122024, 3'd1, 32'h31122024, 3'd1, 0, 0, 1, 0);
      add(2'd0, 1, 1, 32'h15062030, 3'd2, 32'h15062030, 3'd2, 0, 0, 1, 0);
      add(2'd0, 0, 1, 32'h0,        3'd0, 32'h16062030, 3'd3, 0, 0, 0, 0);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL collision step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   task automatic test_two_digit();
      stim_t st; obs_t o, e; int n = 0;
      add(2'd1, 1, 0, 32'h00280200, 3'd0, 32'h00280200, 3'd0, 0, 0, 1, 0);
      add(2'd1, 0, 1, 32'h0,        3'd0, 32'h00010300, 3'd1, 1, 0, 0, 0);
      add(2'd2, 1, 0, 32'h00280200, 3'd0, 32'h00280200, 3'd0, 0, 0, 1, 0);
      add(2'd2, 0, 1, 32'h0,        3'd0, 32'h00290200, 3'd1, 0, 0, 0, 0);
      add(2'd2, 1, 0, 32'h00311299, 3'd6, 32'h00311299, 3'd6, 0, 0, 1, 0);
      add(2'd2, 0, 1, 32'h0,        3'd0, 32'h00010100, 3'd0, 1, 1, 0, 0);
      add(2'd2, 1, 0, 32'h00090924, 3'd0, 32'h00090924, 3'd0, 0, 0, 1, 0);
      add(2'd2, 0, 1, 32'h0,        3'd0, 32'h00100924, 3'd1, 0, 0, 0, 0);
      add(2'd2, 1, 0, 32'h00300924, 3'd0, 32'h00300924, 3'd0, 0, 0, 1, 0);
      add(2'd2, 0, 1, 32'h0,        3'd0, 32'h00011024, 3'd1, 1, 0, 0, 0);
      add(2'd2, 1, 0, 32'h00290223, 3'd0, 32'h00011024, 3'd1, 0, 0, 0, 1);
      while (stim_q.size() > 0) begin
         st = stim_q.pop_front(); sb.push_back(st.exp); drive(st);
         o = observe(st.g); e = sb.pop_front(); tests++;
         if (o !== e) begin fails++; $display("FAIL two_digit step %0d: got %s expected %s", n, fmt(o), fmt(e)); end
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      tick0 = 1'b0; set0 = 1'b0; sd0 = '0; sw0 = '0;
      tick2 = 1'b0; set2 = 1'b0; sd2 = '0; sw2 = '0;
      test_reset();
      test_leap();
      test_day_advance();
      test_year_rollover();
      test_validation();
      test_collision();
      test_two_digit();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/calendar_bcd.md
Name: calendar_bcd

Overview:
Parametrised BCD calendar counter. It is the successor to the 2000–2099 date block and holds day, month, year and weekday. It advances one day per `day_tick` pulse from the timekeeping chain and applies full Gregorian leap rules. It accepts validated date loads from the set-mode controller and reports invalid loads. Its outputs feed the display mux and the alarm/date comparators.

Parameters:
- YEAR_DIGITS, 4, number of BCD year digits; legal values are 2 or 4. YW = 4*YEAR_DIGITS.
- BASE_CENTURY, 8'h20, BCD century used for leap decisions when YEAR_DIGITS=2. Ignored when YEAR_DIGITS=4.
- RESET_DAY, 8'h01, BCD day loaded on reset.
- RESET_MONTH, 8'h01, BCD month loaded on reset.
- RESET_YEAR, 16'h2000, BCD year loaded on reset. Only the low YW bits are used.
- RESET_WEEKDAY, 3'd5, weekday loaded on reset. Encoding is 0=Mon … 6=Sun, so 1-Jan-2000 is Sat.

Ports:
- clk, input, 1, system clock (mclk domain). Single clock.
- rst_n, input, 1, asynchronous active-low reset.
- day_tick, input, 1, one-cycle pulse at midnight rollover (hour 23→00), generated upstream.
- set_en, input, 1, one-cycle load request.
- set_date, input, 16+YW, requested date as {day[7:0], month[7:0], year[YW-1:0]} in BCD.
- set_weekday, input, 3, requested weekday.
- date_out, output, 16+YW, {day, month, year} in BCD.
- weekday_out, output, 3, current weekday.
- month_tick, output, 1, one-cycle pulse when month advanced.
- year_tick, output, 1, one-cycle pulse when year advanced.
- set_ack, output, 1, one-cycle pulse when a load was accepted.
- set_err, output, 1, one-cycle pulse when a load was rejected.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - date_out = {RESET_DAY, RESET_MONTH, RESET_YEAR[YW-1:0]}, weekday_out = RESET_WEEKDAY.
  - All pulse outputs = 0.
  - Reset asserted mid-operation overrides any pending set or tick.
- All state is registered. Latency is 1 cycle: the event sampled at edge N gives new values and pulses visible after edge N; pulses last exactly one cycle.
- Priority: set_en > day_tick. If both are high in the same cycle, the set is processed and the tick is discarded. This applies even if the set is rejected.
- Day advance (day_tick=1, set_en=0):
  - If day < last_day(month, year): day increments with BCD carry (09→10, 19→20, 29→30).
  - Otherwise day=01 and the month advances:
    - 09→10, other months increment with BCD carry.
    - 12→01, and the year advances.
  - The year increments as a YW-bit BCD counter with carry through all digits and wraps at all 9s to all 0s (9999→0000; for 2 digits, 99→00).
  - weekday: 6→0, else +1. It advances on every accepted tick.
  - month_tick = 1 on a month change; year_tick = 1 on a year change. Both are high together at Dec 31.
- last_day:
  - 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11.
  - Feb: 29 if leap, else 28.
- Leap rule, with YY = low two BCD year digits and CC = century (year[15:8] if YEAR_DIGITS=4, else BASE_CENTURY):
  - YY≠00: leap iff YY mod 4 = 0. In BCD: tens even and ones ∈ {0,4,8}, or tens odd and ones ∈ {2,6}.
  - YY=00: leap iff CC mod 4 = 0, using the same BCD test on CC.
  - This gives 2000 leap, 2100/1900 not leap, 2400 leap.
- Set validation is combinational on set_date/set_weekday. A load is valid iff all of the following hold:
  - every nibble ≤ 9;
  - month in 01..12;
  - day in 01..last_day(set month, set year);
  - set_weekday ≤ 6.
- Set outcome:
  - Valid: load all fields next edge and pulse set_ack.
  - Invalid: registers unchanged and pulse set_err.
  - month_tick and year_tick are never pulsed by a load.
- Weekday is not checked against the date; consistency is the set controller's responsibility.
- Internal state only ever holds valid dates (reset values are assumed legal by the parameter choice). No tick can produce an invalid date.

Test Plan:
1. Reset → hold rst_n=0 mid-cycle → date_out=01/01/2000 immediately (asynchronous), weekday_out=5, all pulses 0.
2. Leap years:
   - Load 28/02/2000, tick → 29/02/2000; tick → 01/03/2000 with month_tick=1.
   - Load 28/02/2100, tick → 01/03/2100.
   - Load 28/02/2024, tick → 29/02/2024.
3. Year rollover → load 31/12/2099 wd=3, tick → 01/01/2100, wd=4, month_tick=year_tick=1 for one cycle. Also check 31/12/9999 → 01/01/0000.
4. Validation:
   - Set 31/04/2024 → set_err=1, date unchanged.
   - Set 29/02/2023 → set_err.
   - Set 1A/01/2024 → set_err.
   - Set wd=7 → set_err.
   - Set 29/02/2024 wd=3 → set_ack=1, loaded.
5. Collision → set_en with 15/06/2030 and day_tick in the same cycle → 15/06/2030 loaded, no increment, set_ack=1, month_tick=0.
6. Two-digit year variant:
   - YEAR_DIGITS=2, BASE_CENTURY=8'h21: 28/02/00, tick → 01/03/00.
   - BASE_CENTURY=8'h20: 28/02/00, tick → 29/02/00.
   - 31/12/99, tick → 01/01/00 with year_tick=1.
   - BCD carry: 09/09 → 10/09, and 30/09, tick → 01/10.
